// File: rtl/bsg_two_fifo_async_reset.sv
// Two-entry ready/valid FIFO with registered outputs and asynchronous reset.
// Producer side uses a valid/ready handshake; consumer side uses valid/yumi.
// Occupancy is held in two flags: EMPTY (empty_q), ONE (neither), FULL (full_q).
module bsg_two_fifo_async_reset
  #(parameter int width_p = -1
  , parameter bit allow_enq_deq_on_full_p = 1'b0
  // Keeps port ranges legal even when width_p is left below 1.
  , localparam int unsigned width_lp = (width_p < 1) ? 1 : width_p
  )
  (input  logic                clock_i
  , input  logic                reset_i
  , input  logic                v_i
  , input  logic [width_lp-1:0] data_i
  , output logic                ready_o
  , output logic                v_o
  , output logic [width_lp-1:0] data_o
  , input  logic                yumi_i
  );

  logic [width_lp-1:0] mem_q [2];
  logic                rptr_q, wptr_q;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                enq, deq;

  // With the parameter set, a dequeue frees the slot the new word lands in.
  assign ready_o = (~full_q | (allow_enq_deq_on_full_p & yumi_i)) & ~reset_i;
  assign v_o     = ~empty_q;
  assign data_o  = mem_q[rptr_q];

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  // Occupancy next state; enq+deq together leaves occupancy unchanged.
  always_comb begin
    full_d  = full_q;
    empty_d = empty_q;
    if (enq && !deq) begin
      empty_d = 1'b0;
      full_d  = ~empty_q;
    end else if (deq && !enq) begin
      full_d  = 1'b0;
      empty_d = ~full_q;
    end
  end

  // Occupancy flags and pointers; pointers wrap as 1-bit counters.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      empty_q <= empty_d;
      if (enq) wptr_q <= ~wptr_q;
      if (deq) rptr_q <= ~rptr_q;
    end
  end

  // Storage; cleared on reset so data_o reads zero until the first enqueue.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (enq) begin
      mem_q[wptr_q] <= data_i;
    end
  end

`ifndef SYNTHESIS
  // Handshake misuse is harmless (ignored) but worth flagging; counters
  // let a bench observe that the checks tripped.
  int unsigned illegal_enq_count = 0;
  int unsigned illegal_deq_count = 0;

  // Simulation-only protocol and parameter checks.
  always_ff @(posedge clock_i) begin
    assert (width_p >= 1) else $error("bsg_two_fifo: width_p must be at least 1");
    if (!reset_i) begin
      assert (!(v_i && !ready_o)) else begin
        $warning("bsg_two_fifo: v_i while not ready, word ignored");
        illegal_enq_count <= illegal_enq_count + 1;
      end
      assert (!(yumi_i && !v_o)) else begin
        $warning("bsg_two_fifo: yumi_i while empty, ignored");
        illegal_deq_count <= illegal_deq_count + 1;
      end
      assert (!(full_q && empty_q)) else $error("bsg_two_fifo: both occupancy flags set");
    end
  end
`endif

endmodule

// File: doc/bsg_two_fifo_async_reset.md
# bsg_two_fifo_async_reset

Two-entry ready/valid FIFO. It is the consuming-side counterpart to our enable-gated register: the producer writes under a valid/ready handshake, and the consumer drains words under a valid/yumi handshake. It sits between pipeline stages that need full throughput with registered outputs, with no combinational path from `v_i` to `v_o` or from `yumi_i` to `ready_o` (when `allow_enq_deq_on_full_p=0`). Storage, pointers and flags all clear asynchronously on reset.

## Interface
- `width_p`, default -1 (must be overridden): data word width in bits, >= 1.
- `allow_enq_deq_on_full_p`, default 0: if 1, `ready_o` also asserts when full and `yumi_i`=1. This creates a combinational `yumi_i`->`ready_o` path.

- `clock_i`  in  1  single clock; all state updates on its rising edge.
- `reset_i`  in  1  asynchronous, active-high reset. Asserting it clears all state immediately. Deassertion is synchronous to `clock_i`, which the system guarantees.
- `v_i`  in  1  producer has a valid word on `data_i`.
- `data_i`  in  width_p  write data.
- `ready_o`  out  1  FIFO accepts a word this cycle. Enqueue occurs when `v_i & ready_o`.
- `v_o`  out  1  head word is valid on `data_o`.
- `data_o`  out  width_p  head word, taken directly from a storage register.
- `yumi_i`  in  1  consumer takes the head this cycle. Legal only when `v_o`=1.

## Operation
- State:
  - `mem[0:1]`, each `width_p` bits.
  - 1-bit `rptr` and 1-bit `wptr`.
  - `full_r` and `empty_r` flags.
  - The three occupancy states are EMPTY (`empty_r`=1), ONE (both flags 0) and FULL (`full_r`=1). The encoding must never have both flags set.
- `enq = v_i & ready_o`; `deq = yumi_i & v_o`.
- Enqueue: `mem[wptr] <= data_i`, `wptr <= ~wptr`.
- Dequeue: `rptr <= ~rptr`.
- Pointers wrap naturally as 1-bit values: 1 -> 0.
- Transitions:
  - EMPTY + enq -> ONE.
  - ONE + enq only -> FULL.
  - ONE + deq only -> EMPTY.
  - ONE + enq + deq -> ONE, with both pointers advancing.
  - FULL + deq -> ONE.
  - FULL + enq + deq (only possible when `allow_enq_deq_on_full_p`=1) -> FULL. The new word is written into the slot being vacated (`wptr` == `rptr`).
  - All other combinations hold state.
- `ready_o = ~full_r & ~reset_i`. When `allow_enq_deq_on_full_p`=1, `ready_o = (~full_r | yumi_i) & ~reset_i`.
- `v_o = ~empty_r`.
- `data_o = mem[rptr]`.
- No fall-through: a word enqueued into EMPTY appears on `v_o`/`data_o` the following cycle.
- Protocol violations:
  - `v_i` with `ready_o`=0: ignored, no write, no state change.
  - `yumi_i` with `v_o`=0: ignored.
  - Simulation-only assertions flag both cases, plus `width_p` < 1.
- Reset value of every output while `reset_i`=1 and in the first cycle after deassertion:
  - `ready_o`=0 during reset, 1 after.
  - `v_o`=0.
  - `data_o`=0, because `mem` resets to all-zero.
  - Pointers reset to 0.
- Reset mid-operation: contents are discarded immediately, with no clock required. Any in-flight handshake in that cycle is lost.

## Timing
- Latency from enqueue to `v_o` is 1 cycle. Throughput is 1 word/cycle in steady state (ONE state with simultaneous enq+deq).
- `ready_o` depends only on `full_r` and `reset_i` when the parameter is 0. `v_o` and `data_o` depend only on registers.
- `data_o` is stable while `v_o`=1 and `yumi_i`=0. The head word must not change without a dequeue.
- Filling from EMPTY takes 2 back-to-back enqueues. `ready_o` falls in the cycle after the second enqueue.

## Test plan
- Reset: assert `reset_i` asynchronously mid-cycle while FULL with 0xA5/0x5A.
  - Required: `v_o`=0, `ready_o`=0 and `data_o`=0 immediately, without a clock edge.
  - After deassertion: `ready_o`=1 on the next cycle, and a subsequent single enqueue of 0x11 appears alone.
- Fill/drain, `width_p`=8: enqueue 0x01 then 0x02 with `yumi_i`=0.
  - Required: `ready_o`=0 after the 2nd edge. A 3rd `v_i` with 0x03 is dropped.
  - Draining yields 0x01, 0x02, then `v_o`=0.
- Streaming: hold `v_i`=1 and `yumi_i`=`v_o` for 10 cycles with data 0..9.
  - Required: outputs 0..9 in order, one per cycle after 1-cycle latency.
  - Pointers wrap at least 4 times, and `ready_o` never drops.
- Full + simultaneous: FULL with 0x10/0x20, then `v_i`=1 with 0x30 and `yumi_i`=1.
  - Parameter 0: 0x30 is rejected. Output 0x10 then 0x20.
  - Parameter 1: 0x30 is accepted. Output 0x10, 0x20, 0x30.
- Head stability: ONE state holding 0x7E, `yumi_i`=0 for 5 cycles while `v_i` enqueues 0x55.
  - Required: `data_o` stays 0x7E until `yumi_i`, then shows 0x55.
- Illegal `yumi_i` while EMPTY: no state change, subsequent order intact, and the assertion fires.
